// File: rtl/rf_wport_sched.sv
// rf_wport_sched: arbitrates the single register-file write port between the
// in-order WB stage and an out-of-band long-latency unit (mul/div). Tracks
// registers with a pending long-latency result and stalls ID on RAW/WAW hits.
//
// Optional feature, macro RF_STARVE_GUARD_EN:
//   defined   - a long-latency result denied STARVE_MAX times in a row is
//               forced onto the port while the pipeline is frozen (wb_hold).
//   undefined - strict writeback priority; wb_hold is tied low and a result
//               may wait indefinitely under continuous writeback.
module rf_wport_sched #(
    parameter int MAX_OUT    = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        wb_hold,
    input  logic        mc_valid,
    output logic        mc_ready,
    input  logic [4:0]  mc_rd,
    input  logic [31:0] mc_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic        issue_ready,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic        id_we,
    output logic        stall_id,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd
);

    // Reject configurations the 4-bit counters cannot represent.
    if (MAX_OUT < 1 || MAX_OUT > 15) begin : g_bad_max_out
        $error("rf_wport_sched: MAX_OUT must be in 1..15");
    end
    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("rf_wport_sched: STARVE_MAX must be in 1..15");
    end

    localparam logic [3:0] MAX_OUT_L = 4'(MAX_OUT);

`ifdef RF_STARVE_GUARD_EN
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,  // no denied long-latency result
        WAIT  = 2'd1,  // current result denied at least once
        FORCE = 2'd2   // result takes the port, pipeline frozen
    } state_t;

    logic [3:0] starve_cnt;
    logic [3:0] starve_next;
`else
    typedef enum logic {
        IDLE = 1'b0,   // no denied long-latency result
        WAIT = 1'b1    // current result denied at least once
    } state_t;
`endif

    state_t      state;
    state_t      state_next;
    logic [31:0] busy;
    logic [3:0]  outstanding;

    logic wb_req;
    logic mc_req;
    logic wb_grant;
    logic mc_grant;
    logic mc_hs;
    logic issue_hs;

    // Writes to x0 never compete for the port.
    assign wb_req   = wb_we & (wb_rd != 5'd0);
    assign mc_req   = mc_valid;
    assign mc_hs    = mc_grant;
    assign issue_hs = issue_valid & issue_ready;

    // Port grant and next-state / starvation bookkeeping.
    // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        state_next = state;
        wb_grant   = 1'b0;
        mc_grant   = 1'b0;
        wb_hold    = 1'b0;
`ifdef RF_STARVE_GUARD_EN
        starve_next = starve_cnt;
`endif
        if (!rst) begin
`ifdef RF_STARVE_GUARD_EN
            if (state == FORCE) begin
                mc_grant = mc_req;
                wb_hold  = 1'b1;
            end else begin
                wb_grant = wb_req;
                mc_grant = mc_req & ~wb_req;
            end
`else
            wb_grant = wb_req;
            mc_grant = mc_req & ~wb_req;
`endif
        end

        if (mc_grant) begin
            state_next = IDLE;
`ifdef RF_STARVE_GUARD_EN
            starve_next = 4'd0;
`endif
        end else if (mc_req) begin
            state_next = WAIT;
`ifdef RF_STARVE_GUARD_EN
            starve_next = starve_cnt + 4'd1;
            if (starve_next == STARVE_LIM) begin
                state_next = FORCE;
            end
`endif
        end
    end

    // Zero-latency write port driven straight from the grant.
    always_comb begin
        rf_we = 1'b0;
        rf_wa = 5'd0;
        rf_wd = 32'd0;
        if (mc_grant) begin
            rf_we = (mc_rd != 5'd0);
            rf_wa = mc_rd;
            rf_wd = mc_data;
        end else if (wb_grant) begin
            rf_we = 1'b1;
            rf_wa = wb_rd;
            rf_wd = wb_data;
        end
    end

    assign mc_ready    = mc_grant;
    assign issue_ready = (outstanding < MAX_OUT_L);

    // Registered busy is used on purpose: a register being written back this
    // cycle is not yet visible to the combinational RF read in ID.
    assign stall_id = (id_use_rs1 & busy[id_rs1])
                    | (id_use_rs2 & busy[id_rs2])
                    | (id_we      & busy[id_rd])
                    | wb_hold;

    // Arbiter state register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

`ifdef RF_STARVE_GUARD_EN
    // Consecutive-denial counter for the pending long-latency result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= 4'd0;
        end else begin
            starve_cnt <= starve_next;
        end
    end
`endif

    // Busy scoreboard: clear on return, set on issue; x0 never busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 32'd0;
        end else begin
            if (mc_hs) begin
                busy[mc_rd] <= 1'b0;
            end
            // NOTE: the later non-blocking write wins, so a same-cycle issue overrides the return's clear.
            if (issue_hs && (issue_rd != 5'd0)) begin
                busy[issue_rd] <= 1'b1;
            end
            busy[0] <= 1'b0;
        end
    end

    // Outstanding long-latency ops; returns with nothing outstanding saturate at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= 4'd0;
        end else if (issue_hs && !mc_hs) begin
            outstanding <= outstanding + 4'd1;
        end else if (!issue_hs && mc_hs && (outstanding != 4'd0)) begin
            outstanding <= outstanding - 4'd1;
        end
    end

endmodule

// File: tb/tb_rf_wport_sched.sv
// Testbench for rf_wport_sched: directed scenarios with literal expectations,
// then protocol-respecting random traffic, all checked every cycle against a
// behavioural model of the write-port scheduler.
module tb_rf_wport_sched;

    localparam int MAX_OUT    = 4;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        wb_hold;
    logic        mc_valid = 1'b0;
    logic        mc_ready;
    logic [4:0]  mc_rd = '0;
    logic [31:0] mc_data = '0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        issue_ready;
    logic [4:0]  id_rs1 = '0;
    logic [4:0]  id_rs2 = '0;
    logic [4:0]  id_rd = '0;
    logic        id_use_rs1 = 1'b0;
    logic        id_use_rs2 = 1'b0;
    logic        id_we = 1'b0;
    logic        stall_id;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    rf_wport_sched #(
        .MAX_OUT    (MAX_OUT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .wb_hold     (wb_hold),
        .mc_valid    (mc_valid),
        .mc_ready    (mc_ready),
        .mc_rd       (mc_rd),
        .mc_data     (mc_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .id_we       (id_we),
        .stall_id    (stall_id),
        .rf_we       (rf_we),
        .rf_wa       (rf_wa),
        .rf_wd       (rf_wd)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_busy[32];
    int m_cnt    = 0;
    int m_denied = 0;
    bit m_force  = 0;

    initial begin
        bit          wb_req, e_mr, e_hold, e_we, e_stall, e_ir, hs, iss;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_rf_we", rf_we, 0);
                check("rst_mc_ready", mc_ready, 0);
                check("rst_wb_hold", wb_hold, 0);
                check("rst_stall_id", stall_id, 0);
                check("rst_issue_ready", issue_ready, 1);
                foreach (m_busy[i]) m_busy[i] = 0;
                m_cnt = 0; m_denied = 0; m_force = 0;
            end else begin
                wb_req = wb_we && (wb_rd != 0);
                e_hold = m_force;
                e_mr   = m_force ? mc_valid : (mc_valid && !wb_req);
                if (e_mr) begin
                    e_we = (mc_rd != 0); e_wa = mc_rd; e_wd = mc_data;
                end else if (!m_force && wb_req) begin
                    e_we = 1; e_wa = wb_rd; e_wd = wb_data;
                end else begin
                    e_we = 0; e_wa = 0; e_wd = 0;
                end
                e_stall = (id_use_rs1 && m_busy[id_rs1]) || (id_use_rs2 && m_busy[id_rs2])
                       || (id_we && m_busy[id_rd]) || e_hold;
                e_ir = (m_cnt < MAX_OUT);
                check("mdl_rf_we", rf_we, e_we);
                check("mdl_rf_wa", rf_wa, e_wa);
                check("mdl_rf_wd", rf_wd, e_wd);
                check("mdl_mc_ready", mc_ready, e_mr);
                check("mdl_wb_hold", wb_hold, e_hold);
                check("mdl_stall_id", stall_id, e_stall);
                check("mdl_issue_ready", issue_ready, e_ir);
                // advance the model to the state after the coming edge
                hs  = mc_valid && e_mr;
                iss = issue_valid && e_ir;
                if (hs) m_busy[mc_rd] = 0;
                if (iss && issue_rd != 0) m_busy[issue_rd] = 1;
                if (iss && !hs) m_cnt++;
                else if (hs && !iss && m_cnt > 0) m_cnt--;
                if (hs) begin
                    m_denied = 0; m_force = 0;
                end else if (mc_valid) begin
                    m_denied++;
`ifdef RF_STARVE_GUARD_EN
                    if (m_denied == STARVE_MAX) m_force = 1;
`endif
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int          q[$];
        bit          fake;
        bit          hs, ihs;
        int          rds[4];

        // Reset values
        at_neg();
        check("reset_rf_wa", rf_wa, 0);
        check("reset_rf_wd", rf_wd, 0);
        at_neg();
        step();
        rst = 1'b0;

        // RAW hazard on a pending long-latency destination
        issue_valid = 1; issue_rd = 7;
        at_neg(); check("raw_issue_ready", issue_ready, 1);
        step(); issue_valid = 0; id_use_rs1 = 1; id_rs1 = 7;
        at_neg(); check("raw_stall_a", stall_id, 1);
        step();
        at_neg(); check("raw_stall_b", stall_id, 1);
        step(); mc_valid = 1; mc_rd = 7; mc_data = 32'hA5A5_0007;
        at_neg();
        check("raw_ret_ready", mc_ready, 1);
        check("raw_ret_wa", rf_wa, 7);
        check("raw_ret_wd", rf_wd, 32'hA5A5_0007);
        check("raw_stall_ret", stall_id, 1);
        step(); mc_valid = 0;
        at_neg(); check("raw_stall_clr", stall_id, 0);
        step(); id_use_rs1 = 0;

        // WB beats a simultaneous long-latency result
        issue_valid = 1; issue_rd = 9;
        step(); issue_valid = 0;
        wb_we = 1; wb_rd = 3; wb_data = 32'h1111_0003;
        mc_valid = 1; mc_rd = 9; mc_data = 32'h2222_0009;
        at_neg();
        check("conf_rf_we", rf_we, 1);
        check("conf_rf_wa", rf_wa, 3);
        check("conf_rf_wd", rf_wd, 32'h1111_0003);
        check("conf_mc_ready", mc_ready, 0);
        step(); wb_we = 0;
        at_neg();
        check("conf2_rf_wa", rf_wa, 9);
        check("conf2_mc_ready", mc_ready, 1);
        step(); mc_valid = 0;

        // Starvation under continuous writeback
        issue_valid = 1; issue_rd = 12;
        step(); issue_valid = 0;
        wb_we = 1; wb_rd = 4; wb_data = 32'h4444_0004;
        mc_valid = 1; mc_rd = 12; mc_data = 32'hCCCC_000C;
        for (int i = 0; i < STARVE_MAX; i++) begin
            at_neg();
            check("starve_denied", mc_ready, 0);
            check("starve_no_hold", wb_hold, 0);
            check("starve_wa_wb", rf_wa, 4);
            step();
        end
`ifdef RF_STARVE_GUARD_EN
        at_neg();
        check("force_hold", wb_hold, 1);
        check("force_stall", stall_id, 1);
        check("force_ready", mc_ready, 1);
        check("force_wa", rf_wa, 12);
        step(); mc_valid = 0;
        at_neg();
        check("force_hold_drop", wb_hold, 0);
        check("force_after_wa", rf_wa, 4);
        step(); wb_we = 0;
`else
        at_neg();
        check("strict_still_denied", mc_ready, 0);
        check("strict_no_hold", wb_hold, 0);
        step(); wb_we = 0;
        at_neg();
        check("strict_ret_ready", mc_ready, 1);
        check("strict_ret_wa", rf_wa, 12);
        step(); mc_valid = 0;
`endif

        // Outstanding limit
        for (int r = 1; r <= 4; r++) begin
            issue_valid = 1; issue_rd = 5'(r);
            at_neg(); check("max_issue_ready", issue_ready, 1);
            step();
        end
        issue_valid = 0;
        at_neg(); check("max_full", issue_ready, 0);
        step(); mc_valid = 1; mc_rd = 1; mc_data = 32'h0000_0001;
        at_neg(); check("max_ret_ready", mc_ready, 1); check("max_still_full", issue_ready, 0);
        step(); mc_valid = 0;
        at_neg(); check("max_reopen", issue_ready, 1);
        step(); issue_valid = 1; issue_rd = 5; mc_valid = 1; mc_rd = 2;
        at_neg(); check("max_both_ready", mc_ready, 1);
        step(); issue_valid = 1; issue_rd = 6; mc_valid = 0;
        at_neg(); check("max_both_unchanged", issue_ready, 1);
        step(); issue_valid = 0;
        at_neg(); check("max_full_again", issue_ready, 0);
        rds = '{3, 4, 5, 6};
        foreach (rds[i]) begin
            step(); mc_valid = 1; mc_rd = 5'(rds[i]); mc_data = 32'(rds[i]);
            at_neg(); check("max_drain_ready", mc_ready, 1);
        end
        step(); mc_valid = 0;
        at_neg(); check("max_drained", issue_ready, 1);

        // x0 writeback does not block mc; same-register set/clear keeps busy
        step();
        wb_we = 1; wb_rd = 0; wb_data = 32'hDEAD_0000;
        mc_valid = 1; mc_rd = 8; mc_data = 32'h8888_0008;
        issue_valid = 1; issue_rd = 8;
        at_neg();
        check("x0_mc_ready", mc_ready, 1);
        check("x0_rf_wa", rf_wa, 8);
        check("x0_rf_we", rf_we, 1);
        step(); wb_we = 0; mc_valid = 0; issue_valid = 0; id_use_rs2 = 1; id_rs2 = 8;
        at_neg(); check("set_wins_stall", stall_id, 1);
        step(); mc_valid = 1; mc_rd = 8;
        at_neg(); check("set_wins_ret_stall", stall_id, 1);
        step(); mc_valid = 0;
        at_neg(); check("set_wins_clear", stall_id, 0);
        step(); id_use_rs2 = 0;
        for (int i = 0; i < MAX_OUT; i++) begin
            issue_valid = 1; issue_rd = 0;
            step();
        end
        issue_valid = 0; id_we = 1; id_rd = 0;
        at_neg();
        check("x0_counts", issue_ready, 0);
        check("x0_not_busy", stall_id, 0);
        for (int i = 0; i < MAX_OUT; i++) begin
            step(); mc_valid = 1; mc_rd = 0; mc_data = 32'h0;
            at_neg();
            check("x0_drain_ready", mc_ready, 1);
            check("x0_drain_we", rf_we, 0);
        end
        step(); mc_valid = 0; id_we = 0;
        at_neg(); check("x0_drained", issue_ready, 1);

        // Reset mid-operation (mid-FORCE when the guard is built in)
        step(); issue_valid = 1; issue_rd = 5;
        step(); issue_valid = 0; id_use_rs1 = 1; id_rs1 = 5;
        wb_we = 1; wb_rd = 4; wb_data = 32'h4444_1004;
        mc_valid = 1; mc_rd = 5; mc_data = 32'h5555_0005;
        for (int i = 0; i < STARVE_MAX; i++) begin
            at_neg(); step();
        end
`ifdef RF_STARVE_GUARD_EN
        check("pre_rst_hold", wb_hold, 1);
`else
        check("pre_rst_hold", wb_hold, 0);
`endif
        check("pre_rst_stall", stall_id, 1);
        rst = 1; #1;
        check("async_rst_hold", wb_hold, 0);
        check("async_rst_ready", mc_ready, 0);
        check("async_rst_we", rf_we, 0);
        check("async_rst_stall", stall_id, 0);
        check("async_rst_issue", issue_ready, 1);
        at_neg();
        step(); rst = 0; wb_we = 0; id_use_rs1 = 0;
        at_neg();
        check("post_rst_ready", mc_ready, 1);
        check("post_rst_wa", rf_wa, 5);
        step(); mc_valid = 0;

        // Random traffic obeying the hold rules of both sources
        fake = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            hs  = mc_valid && mc_ready;
            ihs = issue_valid && issue_ready && !rst;
            @(posedge clk); #1;
            if (c == 1500) rst = 1;
            if (c == 1503) rst = 0;
            if (ihs) q.push_back(int'(issue_rd));
            if (hs) begin
                if (!fake && q.size() > 0) void'(q.pop_front());
                mc_valid = 0;
            end
            if (!mc_valid) begin
                if (q.size() > 0 && $urandom_range(0, 2) != 0) begin
                    mc_valid = 1; mc_rd = 5'(q[0]); fake = 0;
                end else if ($urandom_range(0, 49) == 0) begin
                    mc_valid = 1; mc_rd = 5'($urandom); fake = 1;
                end
                mc_data = $urandom;
            end
            if (!wb_hold) begin
                wb_we   = ($urandom_range(0, 9) < 7);
                wb_rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                wb_data = $urandom;
            end
            issue_valid = ($urandom_range(0, 2) == 0);
            issue_rd    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
            id_rs1      = 5'($urandom);
            id_rs2      = 5'($urandom);
            id_rd       = 5'($urandom);
            id_use_rs1  = 1'($urandom);
            id_use_rs2  = 1'($urandom);
            id_we       = 1'($urandom);
        end
        at_neg();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rf_wport_sched.md
Name: rf_wport_sched

Overview:
- Schedules the register file's single write port between two sources: the in-order pipeline writeback and a long-latency unit (mul/div) that returns results out of band.
- Keeps a busy scoreboard of registers that have a pending long-latency result.
- Raises an ID-stage stall on RAW and WAW hazards against that scoreboard.
- Sits between the WB stage, the long-latency unit and the register file write inputs (we/rd_addr/data).

Parameters:
- MAX_OUT, 4: maximum number of outstanding long-latency ops; range 1-15.
- STARVE_MAX, 4: number of consecutive denied cycles of a pending long-latency result before it is forced onto the port; range 1-15.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- wb_we  in  1  pipeline writeback request
- wb_rd  in  5  pipeline writeback destination
- wb_data  in  32  pipeline writeback data (already rf_wsel-muxed)
- wb_hold  out  1  freeze pipeline from WB backwards; WB inputs must stay stable while high
- mc_valid  in  1  long-latency result valid; held until mc_ready
- mc_ready  out  1  long-latency result accepted this cycle
- mc_rd  in  5  long-latency destination
- mc_data  in  32  long-latency result
- issue_valid  in  1  ID dispatching a long-latency op
- issue_rd  in  5  destination of the dispatched op
- issue_ready  out  1  outstanding count below MAX_OUT
- id_rs1  in  5  ID source 1
- id_rs2  in  5  ID source 2
- id_rd  in  5  ID destination
- id_use_rs1  in  1  ID reads rs1
- id_use_rs2  in  1  ID reads rs2
- id_we  in  1  ID writes rd
- stall_id  out  1  hazard stall to ID
- rf_we  out  1  register file write enable
- rf_wa  out  5  register file write address
- rf_wd  out  32  register file write data

Behaviour:
- Reset (async, while rst=1):
  - busy[31:0]=0, outstanding=0, starve_cnt=0, state=IDLE.
  - rf_we=0, mc_ready=0, wb_hold=0, stall_id=0, issue_ready=1.
- Effective requests:
  - wb_req = wb_we & (wb_rd!=0).
  - mc_req = mc_valid.
  - A write to x0 never occupies the port.
- States:
  - IDLE: no denied mc result.
  - WAIT: mc_valid was denied at least once.
  - FORCE: mc has priority.
- Grant in IDLE/WAIT:
  - wb_req wins.
  - mc_ready = mc_req & ~wb_req.
  - wb_hold = 0.
- Grant in FORCE:
  - mc_ready = mc_req; wb_hold = 1; wb is not written.
  - Next state IDLE on mc handshake.
- Write port is combinational from the grant, zero latency:
  - mc grant: rf_we=(mc_rd!=0), rf_wa=mc_rd, rf_wd=mc_data.
  - wb grant: rf_we=1, rf_wa=wb_rd, rf_wd=wb_data.
  - Otherwise: rf_we=0, rf_wa=0, rf_wd=0.
- Starvation counter:
  - starve_cnt increments when mc_req & ~mc_ready; cleared on mc handshake.
  - When it increments to STARVE_MAX, next state is FORCE.
  - IDLE->WAIT on first denial; WAIT->IDLE on handshake.
- Scoreboard:
  - Issue handshake = issue_valid & issue_ready.
  - On issue, busy[issue_rd] is set unless issue_rd=0.
  - On mc handshake, busy[mc_rd] is cleared.
  - Same register set and cleared in the same cycle: set wins.
  - busy[0] is constant 0.
- Outstanding count:
  - Incremented on issue, decremented on mc handshake; both in the same cycle leaves it unchanged.
  - issue_ready = outstanding < MAX_OUT.
  - Issues to x0 count as outstanding and must still drain.
- Hazard stall:
  - stall_id = (id_use_rs1 & busy[id_rs1]) | (id_use_rs2 & busy[id_rs2]) | (id_we & busy[id_rd]) | wb_hold.
  - Uses registered busy: a register cleared this cycle still stalls this cycle, because the RF is read combinationally before the write lands.
- Protocol violation: mc handshake with outstanding=0 asserts nothing; the counter saturates at 0.
- Reset mid-FORCE: returns to IDLE and drops wb_hold immediately; the pending mc result is re-presented after reset.

Optional Feature:
- Macro: RF_STARVE_GUARD_EN.
- Defined: FORCE state and starve_cnt exist as described.
- Undefined:
  - Strict wb priority; starve_cnt and FORCE are removed; wb_hold is tied to 0.
  - mc can be starved indefinitely under continuous writeback.

Test Plan:
- Reset with rst=1 mid-operation, busy[5]=1, state FORCE -> all outputs at reset values immediately, busy cleared, state IDLE.
- issue_valid, issue_rd=7; next cycle id_use_rs1, id_rs1=7 -> stall_id=1 until mc handshake with mc_rd=7; stall_id=0 the cycle after.
- wb_we with wb_rd=3 and mc_valid with mc_rd=9 in the same cycle -> rf_we=1, rf_wa=3, mc_ready=0; next cycle wb_we=0 -> rf_wa=9, mc_ready=1.
- Continuous wb_we (rd=4), mc_valid held, STARVE_MAX=4 -> 4 denied cycles, then wb_hold=1, stall_id=1, mc_ready=1, rf_wa=mc_rd; wb_hold drops the next cycle.
- MAX_OUT=4: four issues without returns -> issue_ready=0; one mc handshake -> issue_ready=1 next cycle; issue and return in the same cycle -> count unchanged.
- wb_we with wb_rd=0 and mc_valid in the same cycle -> mc_ready=1 and rf_wa=mc_rd; issue_rd=0 -> busy unchanged, outstanding incremented.
